irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Vectored interrupt controller with request/acknowledge/end-of-interrupt handshake.
- Captures rising edges on WIDTH interrupt sources into a pending register and applies a programmable mask.
- Presents the highest-index eligible source to the CPU as a registered request plus binary id; higher index means higher priority.
- Sits between peripheral interrupt lines and the core's exception entry logic.

Parameters:
- WIDTH, 8, number of interrupt sources (2..32). ID_W = $clog2(WIDTH).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- irq_src  input  WIDTH  raw interrupt lines from peripherals.
- mask_we  input  1  mask write strobe.
- mask_wdata  input  WIDTH  new mask value (1 = source masked).
- mask  output  WIDTH  current mask register.
- pending  output  WIDTH  current pending register.
- irq_req  output  1  interrupt request to CPU.
- irq_id  output  ID_W  id of the presented or in-service source.
- irq_ack  input  1  single-cycle CPU acknowledge.
- irq_eoi  input  1  single-cycle end-of-interrupt.
- in_service  output  1  high from accepted ack until eoi.

Behaviour:
- Reset values:
  - mask = all ones.
  - pending = 0, src_q = 0, irq_req = 0, irq_id = 0, in_service = 0.
  - State = IDLE.
- Reset mid-handshake aborts the handshake immediately; no pending state survives.
- Edge capture:
  - rise = irq_src & ~src_q; src_q <= irq_src every cycle.
  - A source already high when reset is released counts as an edge.
- Pending update: pending <= (pending & ~clr) | rise, where clr is one-hot of irq_id on an accepted ack.
  - Set wins over clear when a new edge arrives on the same bit in the ack cycle.
- Mask write: mask <= mask_wdata on the cycle after mask_we is sampled. Masking never clears pending.
- eligible = pending & ~mask; sel = highest set index of eligible.
- Latency: edge sampled in cycle N -> pending bit set at N+1 -> irq_req = 1 with irq_id = sel at N+2.
- IDLE:
  - If eligible != 0: irq_id <= sel, irq_req <= 1, go to REQ.
  - irq_ack and irq_eoi are ignored.
- REQ:
  - irq_id is held stable; no re-arbitration, even if a higher-priority source becomes pending.
  - If mask[irq_id] = 1 (presented source masked): irq_req <= 0, go to IDLE.
  - Else if irq_ack: pending[irq_id] cleared, irq_req <= 0, in_service <= 1, go to SVC.
  - The masked check has priority over ack in the same cycle.
- SVC:
  - irq_id is held; irq_ack is ignored.
  - On irq_eoi: in_service <= 0, go to IDLE.
  - Re-arbitration happens in IDLE, so the next irq_req rises at the earliest 2 cycles after eoi.
- irq_eoi outside SVC is ignored.
- No nesting: pending bits accumulate during SVC and are served in priority order afterwards.
- irq_ack and irq_eoi are treated as levels sampled per cycle. Holding irq_ack longer than one cycle is harmless because ack is ignored in SVC.

Optional Feature:
- Macro: IRQ_LEVEL_EN.
- Defined (level-sensitive sources):
  - pending <= irq_src every cycle; edge capture is removed; ack does not clear pending.
  - The ISR must deassert the source before eoi. If still asserted after eoi, the same source is re-requested.
- Undefined: edge-triggered behaviour as above.

Test Plan:
- Reset, mask write 8'h00, pulse irq_src[3] for 1 cycle -> pending = 8'h08 after 1 cycle; irq_req = 1, irq_id = 3 after 2 cycles; ack -> pending = 0, in_service = 1; eoi -> in_service = 0, irq_req stays 0.
- Mask 8'h00, pulse irq_src[1] and irq_src[6] in the same cycle -> id 6 presented first; ack, eoi -> id 1 presented 2 cycles after eoi; ack, eoi -> pending = 0.
- Mask 8'h00, source 2 presented (REQ), then pulse irq_src[7] before ack -> irq_id stays 2 until ack; after eoi id 7 presented.
- Source 4 presented, write mask 8'h10 -> irq_req drops the cycle after mask updates, pending[4] stays 1; write mask 8'h00 -> id 4 re-presented.
- Ack for id 5 in the same cycle as a new rising edge on irq_src[5] -> pending[5] remains 1; after eoi id 5 presented again.
- Assert rst during SVC with pending = 8'h22 -> next cycle all outputs at reset values, mask = 8'hFF.
- Stray ack in IDLE and stray eoi in REQ -> no state change.

Source files
------------

// File: rtl/irq_controller_if.sv
// CPU-side bus of the interrupt controller: mask programming, status
// read-back and the request/acknowledge/end-of-interrupt handshake.
// The controller connects through the slave modport and the CPU (or bench)
// through the master modport.
interface irq_controller_if #(
  parameter int WIDTH = 8
);
  localparam int ID_W = $clog2(WIDTH);

  logic             mask_we;
  logic [WIDTH-1:0] mask_wdata;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] pending;
  logic             irq_req;
  logic [ID_W-1:0]  irq_id;
  logic             irq_ack;
  logic             irq_eoi;
  logic             in_service;

  modport master (
    output mask_we, mask_wdata, irq_ack, irq_eoi,
    input  mask, pending, irq_req, irq_id, in_service
  );

  modport slave (
    input  mask_we, mask_wdata, irq_ack, irq_eoi,
    output mask, pending, irq_req, irq_id, in_service
  );
endinterface

// File: rtl/irq_controller.sv
// Vectored interrupt controller. Captures rising edges on WIDTH sources into
// a pending register, applies a programmable mask (1 = masked) and presents
// the highest-index eligible source as a registered request plus binary id.
// The handshake runs IDLE -> REQ (presented) -> SVC (acknowledged) -> IDLE on
// end-of-interrupt; there is no nesting, later requests wait in pending.
// Build option IRQ_LEVEL_EN: pending simply follows the raw source levels,
// edge capture is removed and an acknowledge does not clear pending.
module irq_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] irq_src,
  irq_controller_if.slave  bus
);
  localparam int ID_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             req_q, req_d;
  logic             svc_q, svc_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic [WIDTH-1:0] eligible;
  logic [ID_W-1:0]  sel;
  logic             ack_take;

`ifndef IRQ_LEVEL_EN
  logic [WIDTH-1:0] src_q, src_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;
`endif

  // Highest set bit of v; index 0 when v is empty (caller checks v first).
  function automatic logic [ID_W-1:0] highest_index(input logic [WIDTH-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r = v[i] ? ID_W'(i) : r;
    end
    return r;
  endfunction

  // One-hot decode of an id into a WIDTH-bit vector.
  function automatic logic [WIDTH-1:0] onehot(input logic [ID_W-1:0] id);
    logic [WIDTH-1:0] one;
    one = {{(WIDTH-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

  // Arbitration inputs: unmasked pending sources and the winning index.
  always_comb begin
    eligible = pending_q & ~mask_q;
    sel      = highest_index(eligible);
    ack_take = (state_q == ST_REQ) && !mask_q[id_q] && bus.irq_ack;
  end

`ifndef IRQ_LEVEL_EN
  // Edge capture; a new edge in the acknowledge cycle beats the clear.
  always_comb begin
    src_d     = irq_src;
    rise      = irq_src & ~src_q;
    clr       = ack_take ? onehot(id_q) : '0;
    pending_d = (pending_q & ~clr) | rise;
  end
`else
  // Level mode: pending mirrors the source lines one cycle late.
  always_comb begin
    pending_d = irq_src;
  end
`endif

  // Mask register and handshake state machine next-state logic.
  always_comb begin
    mask_d  = bus.mask_we ? bus.mask_wdata : mask_q;
    state_d = state_q;
    req_d   = req_q;
    svc_d   = svc_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (eligible != '0) begin
          id_d    = sel;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Id is frozen here; a masked presentation is withdrawn even if
        // the CPU acknowledges in the same cycle.
        if (mask_q[id_q]) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (ack_take) begin
          req_d   = 1'b0;
          svc_d   = 1'b1;
          state_d = ST_SVC;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SVC: begin
        if (bus.irq_eoi) begin
          svc_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SVC;
        end
      end
      default: begin
        req_d   = 1'b0;
        svc_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state registers; reset aborts any handshake in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      mask_q    <= {WIDTH{1'b1}};
      req_q     <= 1'b0;
      svc_q     <= 1'b0;
      id_q      <= '0;
`ifndef IRQ_LEVEL_EN
      src_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      req_q     <= req_d;
      svc_q     <= svc_d;
      id_q      <= id_d;
`ifndef IRQ_LEVEL_EN
      src_q     <= src_d;
`endif
    end
  end

  assign bus.mask       = mask_q;
  assign bus.pending    = pending_q;
  assign bus.irq_req    = req_q;
  assign bus.irq_id     = id_q;
  assign bus.in_service = svc_q;
endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller (WIDTH = 8): directed scenarios with
// literal expectations, then randomized traffic, all compared every cycle
// against a transaction-level reference model.
module tb_irq_controller;
  localparam int W  = 8;
  localparam int IW = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] irq_src = '0;

  irq_controller_if #(.WIDTH(W)) bus ();

  irq_controller #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_src (irq_src),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Reference model: what the CPU can observe, plus the previous source levels.
  typedef struct packed {
    logic [W-1:0]  mask;
    logic [W-1:0]  pend;
    logic [W-1:0]  prev;
    logic          req;
    logic          svc;
    logic [IW-1:0] id;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mask = 8'hFF;
    r.pend = 8'h00;
    r.prev = 8'h00;
    r.req  = 1'b0;
    r.svc  = 1'b0;
    r.id   = 3'd0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, logic r, logic [W-1:0] src,
                                    logic mwe, logic [W-1:0] mwd,
                                    logic ack, logic eoi);
    mdl_t n;
    logic [W-1:0] clr;
    int best;
    if (r) return mdl_reset();
    n   = s;
    clr = 8'h00;
    if (s.req) begin
      if (s.mask[s.id]) begin
        n.req = 1'b0;
      end else if (ack) begin
        n.req = 1'b0;
        n.svc = 1'b1;
        clr[s.id] = 1'b1;
      end
    end else if (s.svc) begin
      if (eoi) n.svc = 1'b0;
    end else begin
      best = -1;
      for (int i = 0; i < W; i++) begin
        if (s.pend[i] && !s.mask[i]) best = i;
      end
      if (best >= 0) begin
        n.req = 1'b1;
        n.id  = best[IW-1:0];
      end
    end
`ifdef IRQ_LEVEL_EN
    n.pend = src;
`else
    n.pend = (s.pend & ~clr) | (src & ~s.prev);
`endif
    n.prev = src;
    if (mwe) n.mask = mwd;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Advance the model on every rising edge with the inputs the DUT samples.
  always @(posedge clk) begin
    m <= mdl_step(m, rst, irq_src, bus.mask_we, bus.mask_wdata, bus.irq_ack, bus.irq_eoi);
  end

  // Compare every observable output on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mask",       32'(bus.mask),       32'(m.mask));
      chk("pending",    32'(bus.pending),    32'(m.pend));
      chk("irq_req",    32'(bus.irq_req),    32'(m.req));
      chk("irq_id",     32'(bus.irq_id),     32'(m.id));
      chk("in_service", 32'(bus.in_service), 32'(m.svc));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [W-1:0] v);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = v;
    cyc();
    bus.mask_we    = 1'b0;
  endtask

  task automatic pulse_src(input logic [W-1:0] v);
    irq_src = v;
    cyc();
    irq_src = '0;
  endtask

  task automatic do_ack();
    bus.irq_ack = 1'b1;
    cyc();
    bus.irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    bus.irq_eoi = 1'b1;
    cyc();
    bus.irq_eoi = 1'b0;
  endtask

  initial begin
    m              = mdl_reset();
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.irq_ack    = 1'b0;
    bus.irq_eoi    = 1'b0;

    // Reset values
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_mask", 32'(bus.mask), 32'h0000_00FF);
    chk("rst_req",  32'(bus.irq_req), 32'h0);
    rst = 1'b0;

    // Single source: latency and full handshake
    write_mask(8'h00);
    pulse_src(8'h08);
    chk("t1_pend", 32'(bus.pending), 32'h08);
    chk("t1_req0", 32'(bus.irq_req), 32'h0);
    cyc();
    chk("t1_req", 32'(bus.irq_req), 32'h1);
    chk("t1_id",  32'(bus.irq_id),  32'h3);
    do_ack();
    chk("t1_ack_pend", 32'(bus.pending),    32'h0);
    chk("t1_ack_svc",  32'(bus.in_service), 32'h1);
    do_eoi();
    chk("t1_eoi_svc", 32'(bus.in_service), 32'h0);
    cyc();
    chk("t1_idle_req", 32'(bus.irq_req), 32'h0);

    // Priority order: 6 before 1
    pulse_src(8'h42);
    cyc();
    chk("t2_id6", 32'(bus.irq_id), 32'h6);
    do_ack();
    do_eoi();
    cyc();
    chk("t2_req1", 32'(bus.irq_req), 32'h1);
    chk("t2_id1",  32'(bus.irq_id),  32'h1);
    do_ack();
    do_eoi();
    chk("t2_pend", 32'(bus.pending), 32'h0);

    // No re-arbitration while presented
    pulse_src(8'h04);
    cyc();
    pulse_src(8'h80);
    cyc();
    chk("t3_id2",   32'(bus.irq_id),  32'h2);
    chk("t3_pend",  32'(bus.pending), 32'h84);
    do_ack();
    do_eoi();
    cyc();
    chk("t3_id7", 32'(bus.irq_id), 32'h7);
    do_ack();
    do_eoi();

    // Masking the presented source withdraws it but keeps it pending
    pulse_src(8'h10);
    cyc();
    chk("t4_id4", 32'(bus.irq_id), 32'h4);
    write_mask(8'h10);
    chk("t4_req_hold", 32'(bus.irq_req), 32'h1);
    cyc();
    chk("t4_req_drop", 32'(bus.irq_req), 32'h0);
    chk("t4_pend",     32'(bus.pending), 32'h10);
    write_mask(8'h00);
    cyc();
    chk("t4_req_again", 32'(bus.irq_req), 32'h1);
    chk("t4_id_again",  32'(bus.irq_id),  32'h4);
    do_ack();
    do_eoi();

    // New edge in the acknowledge cycle survives the clear
    pulse_src(8'h20);
    cyc();
    bus.irq_ack = 1'b1;
    irq_src     = 8'h20;
    cyc();
    bus.irq_ack = 1'b0;
    irq_src     = '0;
    chk("t5_pend", 32'(bus.pending),    32'h20);
    chk("t5_svc",  32'(bus.in_service), 32'h1);
    do_eoi();
    cyc();
    chk("t5_id5", 32'(bus.irq_id),  32'h5);
    chk("t5_req", 32'(bus.irq_req), 32'h1);
    do_ack();
    do_eoi();

    // Reset during service
    pulse_src(8'h20);
    cyc();
    do_ack();
    pulse_src(8'h22);
    chk("t6_pend_pre", 32'(bus.pending), 32'h22);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_mask", 32'(bus.mask),       32'hFF);
    chk("t6_pend", 32'(bus.pending),    32'h0);
    chk("t6_svc",  32'(bus.in_service), 32'h0);
    chk("t6_id",   32'(bus.irq_id),     32'h0);

    // Stray ack in IDLE, stray eoi in REQ
    write_mask(8'h00);
    do_ack();
    chk("t7_ack_svc", 32'(bus.in_service), 32'h0);
    pulse_src(8'h01);
    cyc();
    do_eoi();
    chk("t7_req", 32'(bus.irq_req),    32'h1);
    chk("t7_id",  32'(bus.irq_id),     32'h0);
    chk("t7_svc", 32'(bus.in_service), 32'h0);
    do_ack();
    do_eoi();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      irq_src        = W'($urandom & $urandom);
      bus.mask_we    = ($urandom_range(0, 15) == 0);
      bus.mask_wdata = W'($urandom & $urandom);
      bus.irq_ack    = ($urandom_range(0, 2) == 0);
      bus.irq_eoi    = ($urandom_range(0, 3) == 0);
      rst            = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst         = 1'b0;
    bus.mask_we = 1'b0;
    bus.irq_ack = 1'b0;
    bus.irq_eoi = 1'b0;
    irq_src     = '0;
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
